fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 82 ++++++++
 tb/tb_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: byte-wide instruction fetch FSM assembling short/long instruction words.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_addr, mem_rd        byte read request at pc (held until mem_ready)
//   mem_data, mem_ready     read data and completion strobe
//   insn_word, insn_ext     fetched instruction word and extension word (0 for short)
//   insn_long, insn_valid   extension present, instruction ready for execute
//   insn_ack                execute stage accepts the issued instruction
//   jump_en, jump_addr      redirect fetch, discarding any partial instruction
//   halt                    stop fetching after the current instruction
//   pc                      address of the next byte to fetch
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    output logic [15:0] insn_word,
    output logic [15:0] insn_ext,
    output logic        insn_long,
    output logic        insn_valid,
    input  logic        insn_ack,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    input  logic        halt,
    output logic [15:0] pc
);
    typedef enum logic [2:0] {FETCH_LO, FETCH_HI, EXT_LO, EXT_HI, ISSUE, HALTED} state_t;
    state_t state;
    logic is_long;
    // Special-long group: opcode bits [4:0] come from the low byte, [15:14] from the byte arriving now.
    assign is_long = (insn_word[4:0] == 5'b11011) && (mem_data[7:6] == 2'b11);
    assign mem_rd = (state == FETCH_LO) || (state == FETCH_HI) || (state == EXT_LO) || (state == EXT_HI);
    assign insn_valid = (state == ISSUE);
    assign mem_addr = pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_LO;
            pc        <= RESET_PC;
            insn_word <= 16'h0000;
            insn_ext  <= 16'h0000;
            insn_long <= 1'b0;
        end else if (jump_en) begin
            // Redirect wins over any read completion or acknowledge this cycle.
            pc        <= jump_addr;
            insn_long <= 1'b0;
            state     <= halt ? HALTED : FETCH_LO;
        end else begin
            case (state)
                FETCH_LO: if (mem_ready) begin
                    insn_word[7:0] <= mem_data;
                    pc             <= pc + 16'd1;
                    state          <= FETCH_HI;
                end
                FETCH_HI: if (mem_ready) begin
                    insn_word[15:8] <= mem_data;
                    pc              <= pc + 16'd1;
                    insn_long       <= 1'b0;
                    if (!is_long) insn_ext <= 16'h0000;
                    state           <= is_long ? EXT_LO : ISSUE;
                end
                EXT_LO: if (mem_ready) begin
                    insn_ext[7:0] <= mem_data;
                    pc            <= pc + 16'd1;
                    state         <= EXT_HI;
                end
                EXT_HI: if (mem_ready) begin
                    insn_ext[15:8] <= mem_data;
                    pc             <= pc + 16'd1;
                    insn_long      <= 1'b1;
                    state          <= ISSUE;
                end
                ISSUE:   if (insn_ack) state <= halt ? HALTED : FETCH_LO;
                HALTED:  if (!halt) state <= FETCH_LO;
                default: state <= FETCH_LO;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer timing, assembly, stalls, jumps, halt and reset.
module tb_fetch_sequencer;
    logic        clk, rst_n, w_rst_n;
    logic [15:0] mem_addr, insn_word, insn_ext, pc, jump_addr;
    logic        mem_rd, insn_long, insn_valid, mem_ready, insn_ack, jump_en, halt;
    logic [7:0]  mem_data;
    logic [15:0] w_mem_addr, w_insn_word, w_insn_ext, w_pc, w_jump_addr;
    logic        w_mem_rd, w_insn_long, w_insn_valid, w_mem_ready, w_insn_ack, w_jump_en, w_halt;
    logic [7:0]  w_mem_data;
    logic [7:0]  img [0:15];
    typedef struct {logic [15:0] w; logic [15:0] e; logic l; logic [15:0] p;} exp_t;
    exp_t sb[$];
    exp_t ex;
    int n_cmp = 0;
    int n_bad = 0;

    assign mem_data   = mem_rd ? img[mem_addr[3:0]] : 8'hEE;
    assign w_mem_data = w_mem_rd ? img[w_mem_addr[3:0]] : 8'hEE;

    fetch_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_ready(mem_ready), .insn_word(insn_word), .insn_ext(insn_ext), .insn_long(insn_long),
        .insn_valid(insn_valid), .insn_ack(insn_ack), .jump_en(jump_en), .jump_addr(jump_addr),
        .halt(halt), .pc(pc)
    );

    fetch_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd), .mem_data(w_mem_data),
        .mem_ready(w_mem_ready), .insn_word(w_insn_word), .insn_ext(w_insn_ext), .insn_long(w_insn_long),
        .insn_valid(w_insn_valid), .insn_ack(w_insn_ack), .jump_en(w_jump_en), .jump_addr(w_jump_addr),
        .halt(w_halt), .pc(w_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!insn_valid && n < 20) begin
            step();
            n++;
        end
        if (!insn_valid) n = -1;
    endtask

    task do_reset;
        rst_n = 1'b0; insn_ack = 1'b0; jump_en = 1'b0; halt = 1'b0; mem_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task check_issue(input int n, input int want_n, input string tag);
        ex = sb.pop_front();
        n_cmp += 5;
        if (n !== want_n) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, n, want_n); end
        if (insn_word !== ex.w) begin n_bad++; $display("FAIL %s word: got %h want %h", tag, insn_word, ex.w); end
        if (insn_ext !== ex.e) begin n_bad++; $display("FAIL %s ext: got %h want %h", tag, insn_ext, ex.e); end
        if (insn_long !== ex.l) begin n_bad++; $display("FAIL %s long: got %b want %b", tag, insn_long, ex.l); end
        if (pc !== ex.p) begin n_bad++; $display("FAIL %s pc: got %h want %h", tag, pc, ex.p); end
    endtask

    task test_reset;
        n_cmp += 7;
        if (pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
        if (insn_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", insn_valid); end
        if (insn_word !== 16'h0000) begin n_bad++; $display("FAIL reset_word: got %h want 0000", insn_word); end
        if (insn_ext !== 16'h0000) begin n_bad++; $display("FAIL reset_ext: got %h want 0000", insn_ext); end
        if (insn_long !== 1'b0) begin n_bad++; $display("FAIL reset_long: got %b want 0", insn_long); end
        if (w_pc !== 16'hFFFF) begin n_bad++; $display("FAIL reset_wrap_pc: got %h want ffff", w_pc); end
        if (w_insn_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wrap_valid: got %b want 0", w_insn_valid); end
    endtask

    task test_short;
        int n;
        img[0] = 8'h10; img[1] = 8'h32;
        sb.push_back('{16'h3210, 16'h0000, 1'b0, 16'h0002});
        do_reset();
        n_cmp += 2;
        if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL short_first_rd: got %b want 1", mem_rd); end
        if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL short_first_addr: got %h want 0000", mem_addr); end
        wait_valid(n);
        check_issue(n, 2, "short");
        insn_ack = 1'b1;
        step();
        insn_ack = 1'b0;
        n_cmp++;
        if (insn_valid !== 1'b0) begin n_bad++; $display("FAIL short_ack_valid: got %b want 0", insn_valid); end
    endtask

    task test_long;
        int n;
        img[0] = 8'h1B; img[1] = 8'hC0; img[2] = 8'hCD; img[3] = 8'hAB;
        sb.push_back('{16'hC01B, 16'hABCD, 1'b1, 16'h0004});
        do_reset();
        wait_valid(n);
        check_issue(n, 4, "long");
    endtask

    task test_wait_states;
        int n;
        img[0] = 8'h34; img[1] = 8'h12;
        sb.push_back('{16'h1234, 16'h0000, 1'b0, 16'h0002});
        do_reset();
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp += 3;
            if (mem_addr !== 16'h0001) begin n_bad++; $display("FAIL wait_addr%0d: got %h want 0001", i, mem_addr); end
            if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL wait_rd%0d: got %b want 1", i, mem_rd); end
            if (insn_valid !== 1'b0) begin n_bad++; $display("FAIL wait_valid%0d: got %b want 0", i, insn_valid); end
        end
        mem_ready = 1'b1;
        wait_valid(n);
        check_issue(n, 1, "wait");
    endtask

    task test_backpressure_jump;
        int n;
        img[0] = 8'h78; img[1] = 8'h56;
        sb.push_back('{16'h5678, 16'h0000, 1'b0, 16'h0002});
        do_reset();
        wait_valid(n);
        check_issue(n, 2, "bp");
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp += 4;
            if (insn_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid%0d: got %b want 1", i, insn_valid); end
            if (insn_word !== ex.w) begin n_bad++; $display("FAIL bp_word%0d: got %h want %h", i, insn_word, ex.w); end
            if (insn_ext !== ex.e) begin n_bad++; $display("FAIL bp_ext%0d: got %h want %h", i, insn_ext, ex.e); end
            if (insn_long !== ex.l) begin n_bad++; $display("FAIL bp_long%0d: got %b want %b", i, insn_long, ex.l); end
        end
        sb.push_back('{16'h5678, 16'h0000, 1'b0, 16'h0102});
        insn_ack = 1'b1; jump_en = 1'b1; jump_addr = 16'h0100;
        step();
        insn_ack = 1'b0; jump_en = 1'b0;
        n_cmp += 3;
        if (mem_addr !== 16'h0100) begin n_bad++; $display("FAIL jump_addr: got %h want 0100", mem_addr); end
        if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL jump_rd: got %b want 1", mem_rd); end
        if (insn_valid !== 1'b0) begin n_bad++; $display("FAIL jump_valid: got %b want 0", insn_valid); end
        wait_valid(n);
        check_issue(n, 2, "jump_fetch");
    endtask

    task test_back_to_back;
        int n;
        img[0] = 8'h1B; img[1] = 8'hC0; img[2] = 8'hCD; img[3] = 8'hAB;
        img[4] = 8'h10; img[5] = 8'h32; img[6] = 8'h1B; img[7] = 8'h5B;
        sb.push_back('{16'hC01B, 16'hABCD, 1'b1, 16'h0004});
        sb.push_back('{16'h3210, 16'h0000, 1'b0, 16'h0006});
        sb.push_back('{16'h5B1B, 16'h0000, 1'b0, 16'h0008});
        do_reset();
        wait_valid(n);
        check_issue(n, 4, "b2b_long");
        for (int k = 0; k < 2; k++) begin
            insn_ack = 1'b1;
            step();
            insn_ack = 1'b0;
            wait_valid(n);
            check_issue(n, 2, k == 0 ? "b2b_short" : "b2b_nearlong");
        end
    endtask

    task test_mid_reset;
        int n;
        img[0] = 8'h1B; img[1] = 8'hC0; img[2] = 8'hCD; img[3] = 8'hAB;
        sb.push_back('{16'hC01B, 16'hABCD, 1'b1, 16'h0004});
        do_reset();
        step();
        step();
        n_cmp++;
        if (mem_addr !== 16'h0002) begin n_bad++; $display("FAIL midrst_ext_addr: got %h want 0002", mem_addr); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (pc !== 16'h0000) begin n_bad++; $display("FAIL midrst_pc: got %h want 0000", pc); end
        if (insn_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", insn_valid); end
        if (insn_word !== 16'h0000) begin n_bad++; $display("FAIL midrst_word: got %h want 0000", insn_word); end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp += 2;
        if (insn_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_rel_valid: got %b want 0", insn_valid); end
        if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL midrst_rel_addr: got %h want 0000", mem_addr); end
        wait_valid(n);
        check_issue(n, 4, "midrst_refetch");
    endtask

    task test_wrap_halt;
        int n;
        img[15] = 8'h21; img[0] = 8'h43;
        w_mem_ready = 1'b1; w_insn_ack = 1'b0; w_halt = 1'b0;
        w_rst_n = 1'b1;
        n = 0;
        while (!w_insn_valid && n < 20) begin
            step();
            n++;
        end
        n_cmp += 3;
        if (n !== 2) begin n_bad++; $display("FAIL wrap_latency: got %0d want 2", n); end
        if (w_insn_word !== 16'h4321) begin n_bad++; $display("FAIL wrap_word: got %h want 4321", w_insn_word); end
        if (w_pc !== 16'h0001) begin n_bad++; $display("FAIL wrap_pc: got %h want 0001", w_pc); end
        w_halt = 1'b1; w_insn_ack = 1'b1;
        step();
        w_insn_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp += 2;
            if (w_mem_rd !== 1'b0) begin n_bad++; $display("FAIL halt_rd%0d: got %b want 0", i, w_mem_rd); end
            if (w_insn_valid !== 1'b0) begin n_bad++; $display("FAIL halt_valid%0d: got %b want 0", i, w_insn_valid); end
            step();
        end
        w_halt = 1'b0;
        step();
        n_cmp += 2;
        if (w_mem_rd !== 1'b1) begin n_bad++; $display("FAIL unhalt_rd: got %b want 1", w_mem_rd); end
        if (w_mem_addr !== 16'h0001) begin n_bad++; $display("FAIL unhalt_addr: got %h want 0001", w_mem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        rst_n = 1'b1; w_rst_n = 1'b1; mem_ready = 1'b1; insn_ack = 1'b0; jump_en = 1'b0;
        jump_addr = 16'h0000; halt = 1'b0;
        w_mem_ready = 1'b1; w_insn_ack = 1'b0; w_jump_en = 1'b0; w_jump_addr = 16'h0000; w_halt = 1'b0;
        #2;
        rst_n = 1'b0; w_rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_short();
        test_long();
        test_wait_states();
        test_backpressure_jump();
        test_back_to_back();
        test_mid_reset();
        test_wrap_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
